// File: rtl/mul_seq_ctrl.sv
// Sequencer for the 32-bit shift-add multiplier: latches operands, clears the
// datapath, runs one MUL pass per multiplier bit, then captures HI/LO and pulses done.
module mul_seq_ctrl #(
  parameter int unsigned MUL_CYCLES = 32,
  parameter logic [5:0]  SIG_IDLE   = 6'b000000,
  parameter logic [5:0]  SIG_MUL    = 6'b011001,
  parameter logic [5:0]  SIG_OUT    = 6'b111111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [63:0] mul_product,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic [5:0]  mul_signal,
  output logic        mul_reset,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_CAPTURE
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        clear;

  // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    mul_signal = SIG_IDLE;
    busy       = 1'b1;
    clear      = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        clear   = 1'b1;
        cnt_d   = 6'(MUL_CYCLES - 1);
        state_d = S_RUN;
      end
      S_RUN: begin
        // The IDLE->MUL code edge on entry is what loads operands into the datapath.
        mul_signal = SIG_MUL;
        if (cnt_q == 6'd0) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      S_CAPTURE: begin
        mul_signal = SIG_OUT;
        hi_d       = mul_product[63:32];
        lo_d       = mul_product[31:0];
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mul_reset = reset | clear;
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign done      = done_q;

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequencer for the 32-bit shift-add multiplier. It accepts a multiply request with two 32-bit operands and holds them stable on the multiplier inputs. It clears the multiplier, drives the 6-bit multiplier function code for exactly one pass per multiplier bit, then captures the 64-bit product into HI/LO result registers and pulses `done`. It sits between the ALU/control unit and the multiplier datapath and owns the multiplier's `Signal` and `reset` inputs.

## Interface
- `MUL_CYCLES`, 32, number of RUN cycles (one per multiplier bit)
- `SIG_IDLE`, 6'b000000, function code driven when not multiplying
- `SIG_MUL`, 6'b011001, multiplier step code
- `SIG_OUT`, 6'b111111, multiplier hold/output code

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `start`  in  1  request; sampled only in IDLE
- `op_a`  in  32  multiplicand, latched when `start` is accepted
- `op_b`  in  32  multiplier, latched when `start` is accepted
- `mul_product`  in  64  product from multiplier datapath
- `mul_a`  out  32  latched multiplicand to datapath
- `mul_b`  out  32  latched multiplier to datapath
- `mul_signal`  out  6  function code to datapath
- `mul_reset`  out  1  clear to datapath
- `busy`  out  1  high in CLEAR, RUN, CAPTURE
- `done`  out  1  one-cycle pulse, result valid in `hi`/`lo`
- `hi`  out  32  product[63:32]
- `lo`  out  32  product[31:0]

## Operation
- States: IDLE, CLEAR, RUN, CAPTURE. 6-bit down-counter `cnt`.
- IDLE: `mul_signal`=SIG_IDLE, `busy`=0. `start`=1 -> latch `op_a`/`op_b` into `mul_a`/`mul_b`, go to CLEAR.
- CLEAR (1 cycle): `mul_reset`=1, `mul_signal`=SIG_IDLE, load `cnt`=MUL_CYCLES-1 -> RUN.
- RUN: `mul_signal`=SIG_MUL; `cnt` decrements each cycle; at `cnt`==0 -> CAPTURE. The IDLE->MUL code edge at RUN entry is what loads operands into the datapath; `mul_a`/`mul_b` must be stable from CLEAR through CAPTURE.
- CAPTURE (1 cycle): `mul_signal`=SIG_OUT; register `hi`<=`mul_product[63:32]`, `lo`<=`mul_product[31:0]`, `done`<=1; -> IDLE.
- `mul_reset` = `reset` OR (state==CLEAR), combinational from registered state.
- `start` outside IDLE is ignored (no queuing); `op_a`/`op_b` changes outside IDLE have no effect.
- Unsigned 64-bit product; no sign handling, no overflow flag.
- `hi`/`lo` hold last result until next CAPTURE or reset.

## Timing
- `start` sampled at edge T (IDLE) -> CLEAR in cycle T+1, RUN cycles T+2..T+33 (32 cycles), CAPTURE T+34, `done`=1 and state IDLE in T+35.
- `busy` high T+1..T+34; low in the `done` cycle.
- `start` in the `done` cycle is accepted: back-to-back throughput one result per 35 cycles.
- Reset values: state IDLE, `cnt`=0, `mul_a`=`mul_b`=0, `hi`=`lo`=0, `done`=0, `busy`=0, `mul_signal`=SIG_IDLE, `mul_reset`=1 while `reset` high.
- Reset at any state (including mid-RUN): next cycle IDLE, `hi`/`lo` cleared, no `done` pulse, aborted operation discarded.
- `reset` and `start` same cycle: reset wins, request dropped.

## Test plan
- `op_a`=3, `op_b`=5, `start` 1 cycle at T -> `busy` T+1..T+34, `done` at T+35, `hi`=0, `lo`=15, `mul_signal`=011001 for exactly 32 cycles.
- `op_a`=`op_b`=32'hFFFFFFFF -> `hi`=32'hFFFFFFFE, `lo`=32'h00000001 at `done`.
- `op_a`=32'h12345678, `op_b`=0 -> `hi`=`lo`=0; then `start` held high continuously during busy with new operands -> ignored, second op starts only in the `done` cycle.
- Back-to-back: 7*9 then 32'h80000000*2 with second `start` in first `done` cycle -> `lo`=63 at T+35, then `hi`=1, `lo`=0 at T+70.
- `reset` pulsed at T+10 during RUN -> IDLE at T+11, `mul_reset`=1 during the reset cycle, `hi`=`lo`=0, no `done` in T+11..T+40.
- `reset` and `start` in same cycle -> remains IDLE, `busy`=0, no `done`.
